// File: rtl/ring_ptr_ctrl_mc.sv
// ring_ptr_ctrl_mc: per-channel circular-buffer pointer controller.
// Each channel tracks a write and a read pointer, each with its own wrap
// (round) bit. Occupancy, full/empty and threshold flags are decoded from
// registered state only. Overflow/underflow are sticky until clr or aclr.
// DEPTH need not be a power of two: pointers wrap explicitly at DEPTH-1.
module ring_ptr_ctrl_mc #(
   parameter int CHANNELS  = 4,
   parameter int DEPTH     = 16,
   parameter int ADDR_W    = 4,
   parameter int AF_THRESH = 12,
   parameter int AE_THRESH = 2
) (
   input  logic                             clk,
   input  logic                             aclr,
   input  logic [CHANNELS-1:0]              i_clr,
   input  logic [CHANNELS-1:0]              i_push,
   input  logic [CHANNELS-1:0]              i_pop,
   output logic [CHANNELS*ADDR_W-1:0]       o_w_addr,
   output logic [CHANNELS*ADDR_W-1:0]       o_r_addr,
   output logic [CHANNELS-1:0]              o_w_round,
   output logic [CHANNELS-1:0]              o_r_round,
   output logic [CHANNELS*(ADDR_W+1)-1:0]   o_count,
   output logic [CHANNELS-1:0]              o_full,
   output logic [CHANNELS-1:0]              o_empty,
   output logic [CHANNELS-1:0]              o_almost_full,
   output logic [CHANNELS-1:0]              o_almost_empty,
   output logic [CHANNELS-1:0]              o_overflow,
   output logic [CHANNELS-1:0]              o_underflow
);

   localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   AF_C     = (ADDR_W+1)'(AF_THRESH);
   localparam logic [ADDR_W:0]   AE_C     = (ADDR_W+1)'(AE_THRESH);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH-1);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [ADDR_W-1:0] r_w_ptr;
      logic [ADDR_W-1:0] r_r_ptr;
      logic              r_w_rnd;
      logic              r_r_rnd;
      logic              r_ovf;
      logic              r_udf;
      logic              w_same_ptr;
      logic              w_full;
      logic              w_empty;
      logic              w_push_acc;
      logic              w_pop_acc;
      logic [ADDR_W:0]   w_count;

      // status decode from registered state and request acceptance
      always_comb begin
         w_same_ptr = (r_w_ptr == r_r_ptr);
         w_empty    = w_same_ptr & (r_w_rnd == r_r_rnd);
         w_full     = w_same_ptr & (r_w_rnd != r_r_rnd);
         if (r_w_rnd == r_r_rnd)
            w_count = {1'b0, r_w_ptr} - {1'b0, r_r_ptr};
         else
            w_count = DEPTH_C - {1'b0, r_r_ptr} + {1'b0, r_w_ptr};
         w_push_acc = i_push[c] & ~w_full;
         w_pop_acc  = i_pop[c]  & ~w_empty;
      end

      // pointer/round advance, sticky error capture; clr wins over requests
      always_ff @(posedge clk or posedge aclr) begin
         if (aclr) begin
            r_w_ptr <= '0;
            r_r_ptr <= '0;
            r_w_rnd <= 1'b0;
            r_r_rnd <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
         end else if (i_clr[c]) begin
            r_w_ptr <= '0;
            r_r_ptr <= '0;
            r_w_rnd <= 1'b0;
            r_r_rnd <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
         end else begin
            if (w_push_acc) begin
               if (r_w_ptr == LAST_PTR) begin
                  r_w_ptr <= '0;
                  r_w_rnd <= ~r_w_rnd;
               end else begin
                  r_w_ptr <= r_w_ptr + 1'b1;
               end
            end
            if (w_pop_acc) begin
               if (r_r_ptr == LAST_PTR) begin
                  r_r_ptr <= '0;
                  r_r_rnd <= ~r_r_rnd;
               end else begin
                  r_r_ptr <= r_r_ptr + 1'b1;
               end
            end
            if (i_push[c] & w_full)
               r_ovf <= 1'b1;
            if (i_pop[c] & w_empty)
               r_udf <= 1'b1;
         end
      end

      assign o_w_addr[c*ADDR_W +: ADDR_W]       = r_w_ptr;
      assign o_r_addr[c*ADDR_W +: ADDR_W]       = r_r_ptr;
      assign o_w_round[c]                       = r_w_rnd;
      assign o_r_round[c]                       = r_r_rnd;
      assign o_count[c*(ADDR_W+1) +: ADDR_W+1]  = w_count;
      assign o_full[c]                          = w_full;
      assign o_empty[c]                         = w_empty;
      assign o_almost_full[c]                   = (w_count >= AF_C);
      assign o_almost_empty[c]                  = (w_count <= AE_C);
      assign o_overflow[c]                      = r_ovf;
      assign o_underflow[c]                     = r_udf;
   end

endmodule

// File: tb/tb_ring_ptr_ctrl_mc.sv
// Directed bench for ring_ptr_ctrl_mc: a DEPTH=16 instance for the main
// sequence and a DEPTH=12 instance for the non-power-of-two wrap.
module tb_ring_ptr_ctrl_mc;

   logic clk = 1'b0;
   logic aclr = 1'b1;
   logic [3:0] clr = '0, push = '0, pop = '0;
   logic [3:0] clr12 = '0, push12 = '0, pop12 = '0;

   logic [15:0] wa16, ra16, wa12, ra12;
   logic [3:0]  wr16, rr16, wr12, rr12;
   logic [19:0] cnt16, cnt12;
   logic [3:0]  full16, empty16, af16, ae16, ovf16, udf16;
   logic [3:0]  full12, empty12, af12, ae12, ovf12, udf12;

   int checks = 0;
   int failures = 0;
   int wt = 0, rt = 0;

   always #5 clk = ~clk;

   ring_ptr_ctrl_mc u_d16 (
      .clk(clk), .aclr(aclr), .i_clr(clr), .i_push(push), .i_pop(pop),
      .o_w_addr(wa16), .o_r_addr(ra16), .o_w_round(wr16), .o_r_round(rr16),
      .o_count(cnt16), .o_full(full16), .o_empty(empty16),
      .o_almost_full(af16), .o_almost_empty(ae16),
      .o_overflow(ovf16), .o_underflow(udf16));

   ring_ptr_ctrl_mc #(.CHANNELS(4), .DEPTH(12), .ADDR_W(4), .AF_THRESH(9), .AE_THRESH(2)) u_d12 (
      .clk(clk), .aclr(aclr), .i_clr(clr12), .i_push(push12), .i_pop(pop12),
      .o_w_addr(wa12), .o_r_addr(ra12), .o_w_round(wr12), .o_r_round(rr12),
      .o_count(cnt12), .o_full(full12), .o_empty(empty12),
      .o_almost_full(af12), .o_almost_empty(ae12),
      .o_overflow(ovf12), .o_underflow(udf12));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one cycle on the DEPTH=12 channel 0 with an occupancy-total model
   task automatic d12_cycle(input logic p, input logic q);
      int c;
      c = wt - rt;
      push12 = {3'b000, p};
      pop12  = {3'b000, q};
      step();
      if (p && c != 12) wt++;
      if (q && c != 0) rt++;
      chk("d12_waddr", 32'(wa12[3:0]), wt % 12);
      chk("d12_raddr", 32'(ra12[3:0]), rt % 12);
      chk("d12_wrnd", 32'(wr12[0]), (wt / 12) % 2);
      chk("d12_rrnd", 32'(rr12[0]), (rt / 12) % 2);
      chk("d12_count", 32'(cnt12[4:0]), wt - rt);
      chk("d12_full", 32'(full12[0]), 32'(wt - rt == 12));
      chk("d12_addr_range", 32'((wa12[3:0] < 4'd12) && (ra12[3:0] < 4'd12)), 1);
   endtask

   initial begin
      #12;
      chk("rst_waddr", 32'(wa16), 0);
      chk("rst_raddr", 32'(ra16), 0);
      chk("rst_count", 32'(cnt16), 0);
      chk("rst_empty", 32'(empty16), 32'hF);
      chk("rst_ae", 32'(ae16), 32'hF);
      chk("rst_full_af", 32'({full16, af16}), 0);
      chk("rst_ovf_udf", 32'({ovf16, udf16}), 0);
      aclr = 1'b0;

      // fill ch0
      push = 4'b0001;
      for (int i = 1; i <= 16; i++) begin
         step();
         chk("fill_count0", 32'(cnt16[4:0]), i);
         chk("fill_waddr0", 32'(wa16[3:0]), i % 16);
         chk("fill_wrnd0", 32'(wr16[0]), 32'(i == 16));
         chk("fill_full0", 32'(full16[0]), 32'(i == 16));
         chk("fill_af0", 32'(af16[0]), 32'(i >= 12));
         chk("fill_ae0", 32'(ae16[0]), 32'(i <= 2));
         chk("fill_others_empty", 32'(empty16[3:1]), 32'h7);
      end
      // push into full ch0
      step();
      chk("ovf_waddr0", 32'(wa16[3:0]), 0);
      chk("ovf_count0", 32'(cnt16[4:0]), 16);
      chk("ovf_set0", 32'(ovf16[0]), 1);
      push = '0;
      step();
      chk("ovf_hold0", 32'(ovf16[0]), 1);

      // drain ch0
      pop = 4'b0001;
      for (int i = 1; i <= 16; i++) begin
         step();
         chk("drain_count0", 32'(cnt16[4:0]), 16 - i);
         chk("drain_raddr0", 32'(ra16[3:0]), i % 16);
      end
      pop = '0;
      chk("drain_rrnd0", 32'(rr16[0]), 1);
      chk("drain_empty0", 32'(empty16[0]), 1);
      chk("drain_ovf0", 32'(ovf16[0]), 1);

      // underflow ch1 then clr overrides push
      pop = 4'b0010;
      step();
      pop = '0;
      chk("udf_raddr1", 32'(ra16[7:4]), 0);
      chk("udf_set1", 32'(udf16[1]), 1);
      chk("udf_count1", 32'(cnt16[9:5]), 0);
      clr = 4'b0010;
      push = 4'b0010;
      step();
      clr = '0;
      push = '0;
      chk("clr_udf1", 32'(udf16[1]), 0);
      chk("clr_waddr1", 32'(wa16[7:4]), 0);
      chk("clr_count1", 32'(cnt16[9:5]), 0);
      chk("clr_ovf0_kept", 32'(ovf16[0]), 1);

      // ch2 steady push+pop at 8 entries
      push = 4'b0100;
      for (int i = 0; i < 8; i++) step();
      chk("ch2_fill", 32'(cnt16[14:10]), 8);
      pop = 4'b0100;
      for (int i = 1; i <= 40; i++) begin
         step();
         chk("ch2_count", 32'(cnt16[14:10]), 8);
         chk("ch2_waddr", 32'(wa16[11:8]), (8 + i) % 16);
         chk("ch2_raddr", 32'(ra16[11:8]), i % 16);
         chk("ch2_wrnd", 32'(wr16[2]), ((8 + i) / 16) % 2);
         chk("ch2_rrnd", 32'(rr16[2]), (i / 16) % 2);
         chk("ch2_full_empty", 32'({full16[2], empty16[2]}), 0);
      end
      push = '0;
      pop = '0;

      // DEPTH=12 instance: fill, then interleaved pops/pushes, then refill
      for (int i = 0; i < 12; i++) d12_cycle(1'b1, 1'b0);
      chk("d12_af_full", 32'(af12[0]), 1);
      for (int j = 0; j < 24; j++) d12_cycle(j % 3 != 0, 1'b1);
      for (int j = 0; j < 16; j++) d12_cycle(1'b1, j % 2 == 0);
      push12 = '0;
      pop12 = '0;

      // async reset while ch0 holds 5 entries
      push = 4'b0001;
      for (int i = 0; i < 5; i++) step();
      push = '0;
      chk("pre_aclr_count0", 32'(cnt16[4:0]), 5);
      #3 aclr = 1'b1;
      #1;
      chk("aclr_count0", 32'(cnt16[4:0]), 0);
      chk("aclr_waddr0", 32'(wa16[3:0]), 0);
      chk("aclr_rounds", 32'({wr16, rr16}), 0);
      chk("aclr_empty", 32'(empty16), 32'hF);
      chk("aclr_ovf", 32'(ovf16), 0);
      #1 aclr = 1'b0;
      push = 4'b0001;
      step();
      push = '0;
      chk("post_aclr_waddr0", 32'(wa16[3:0]), 1);
      chk("post_aclr_count0", 32'(cnt16[4:0]), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ring_ptr_ctrl_mc.md
Name: ring_ptr_ctrl_mc

Overview:
- Multi-channel circular-buffer pointer controller. It generalises the single wrap ("round") flag tracker into per-channel write/read address generation, round bits, occupancy count, full/empty and threshold flags, and sticky error flags.
- It sits between the convolution engine's line/weight buffer RAMs and their producers/consumers.
- The RAMs are addressed directly from w_addr/r_addr.
- DEPTH need not be a power of two.

Parameters:
- CHANNELS, 4: number of independent ring buffers.
- DEPTH, 16: entries per channel. Legal range: 2 ≤ DEPTH ≤ 2^ADDR_W.
- ADDR_W, 4: address width per channel.
- AF_THRESH, 12: almost_full asserts when count ≥ AF_THRESH. Legal range: 1..DEPTH.
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH. Legal range: 0..DEPTH-1.

Ports:
- clk, input, 1: clock.
- aclr, input, 1: reset; asynchronous, active-high.
- clr, input, CHANNELS: per-channel synchronous clear.
- push, input, CHANNELS: per-channel write request.
- pop, input, CHANNELS: per-channel read request.
- w_addr, output, CHANNELS*ADDR_W: write pointers; channel c occupies bits [c*ADDR_W +: ADDR_W].
- r_addr, output, CHANNELS*ADDR_W: read pointers, same packing.
- w_round, output, CHANNELS: write wrap bit.
- r_round, output, CHANNELS: read wrap bit.
- count, output, CHANNELS*(ADDR_W+1): occupancy per channel.
- full, output, CHANNELS: per-channel full flag.
- empty, output, CHANNELS: per-channel empty flag.
- almost_full, output, CHANNELS: count ≥ AF_THRESH.
- almost_empty, output, CHANNELS: count ≤ AE_THRESH.
- overflow, output, CHANNELS: sticky; set by a rejected push.
- underflow, output, CHANNELS: sticky; set by a rejected pop.

Behaviour:
- Channels are fully independent. There is no shared state and no arbitration between channels.
- State per channel: w_ptr, r_ptr (ADDR_W bits), w_rnd, r_rnd, ovf, udf. All registers are clocked on posedge clk and cleared asynchronously by aclr.
- Reset values for all channels:
  - pointers 0, rounds 0, count 0
  - empty=1, full=0, almost_empty=1 (AE_THRESH ≥ 0), almost_full=0 (AF_THRESH ≥ 1)
  - overflow=0, underflow=0
- Acceptance rules, evaluated on current registered state:
  - push_acc = push & ~full
  - pop_acc = pop & ~empty
- A push on a full channel is rejected, and the channel's overflow bit is set on the next edge. A pop on an empty channel is rejected, and the underflow bit is set on the next edge.
- Simultaneous push and pop on the same channel:
  - Both are accepted when the channel is neither full nor empty.
  - When full: the pop is accepted; the push is rejected and flags overflow.
  - When empty: the push is accepted; the pop is rejected and flags underflow.
  - The write slot never aliases the read slot in the same cycle.
- Pointer advance on acceptance:
  - If ptr == DEPTH-1, then ptr ← 0 and the associated round bit toggles.
  - Otherwise ptr ← ptr+1.
  - Address values ≥ DEPTH are never produced.
- Status outputs are combinational decodes of registered state only. There is no combinational path from push/pop/clr to any output. Status updates one cycle after an accepted operation.
  - empty = (w_ptr == r_ptr) & (w_rnd == r_rnd)
  - full = (w_ptr == r_ptr) & (w_rnd != r_rnd)
  - count = (w_rnd == r_rnd) ? w_ptr - r_ptr : DEPTH - r_ptr + w_ptr, computed at ADDR_W+1 bits. count = DEPTH exactly when full.
- clr[c], synchronous:
  - On the next edge, channel c returns to its reset values, including overflow and underflow.
  - clr overrides push/pop on that channel in the same cycle; the requests are neither accepted nor flagged.
  - Other channels are unaffected.
- aclr asserted mid-operation immediately forces every channel to reset values, regardless of clk. On deassertion, the first edge behaves as for a freshly reset block.
- overflow and underflow hold until clr[c] or aclr.

Test Plan:
- Reset, then 16 pushes on ch0 (DEPTH=16) → after the 16th: w_addr0=0, w_round0=1, full0=1, count0=16, almost_full0 first set after push 12. Other channels stay empty=1.
- A 17th push on full ch0 → w_addr0 stays 0, count0=16, overflow0=1 from the next cycle and held. Then 16 pops → r_round0=1, empty0=1, overflow0 still 1.
- Pop on empty ch1 → r_addr1 stays 0, underflow1=1. Then clr[1] with push[1]=1 in the same cycle → next cycle underflow1=0, w_addr1=0, count1=0.
- ch2 holding 8 entries, push+pop every cycle for 40 cycles → count2 constant at 8. Pointers wrap 15→0 with round toggles; full and empty never assert.
- DEPTH=12 build: 12 pushes → w_addr 11→0, w_round=1, full=1, count=12. Interleaved pops → count matches the formula across the wrap, and no address ≥ 12 is ever output.
- aclr pulse asynchronous to clk while ch0 holds 5 entries → all outputs at reset values before the next clk edge. A push on the first edge after release → w_addr0=1, count0=1.
